// File: rtl/mem_pipe_pkg.sv
// Shared types for the MEM -> EX boundary.
// One queue entry carries a translated MEM-stage result.
package mem_pipe_pkg;

  localparam int EIP_W     = 32;
  localparam int PA_W      = 32;
  localparam int IE_TYPE_W = 4;
  localparam int BR_W      = 32;

  localparam int IE_PROT = 0;
  localparam int IE_PF   = 1;

  typedef struct packed {
    logic [EIP_W-1:0]     eip;
    logic [PA_W-1:0]      pa;
    logic                 ie;
    logic [IE_TYPE_W-1:0] ie_type;
    logic [BR_W-1:0]      br_target;
    logic                 br_tnt;
  } mem_ex_entry_t;

  localparam int ENTRY_W = $bits(mem_ex_entry_t);

  function automatic logic ie_is_mmu(
    input logic [IE_TYPE_W-1:0] t
  );
    return t[IE_PROT] | t[IE_PF];
  endfunction

endpackage

// File: rtl/mem_ex_queue_ctl.sv
// Pointer, occupancy and fence control for mem_ex_queue.
// Flush and reset discard any concurrent push or pop.
module mem_ex_queue_ctl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic                     ready_in,
  input  logic                     ie_in,
  output logic                     push,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fenced
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fence_q, fence_d;
  logic          pop;

  assign ready_out = (count_q < CW'(DEPTH)) & ~fence_q;
  assign valid_out = (count_q != '0);
  assign push      = valid_in & ready_out & ~flush;
  assign pop       = valid_out & ready_in & ~flush;

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign fenced = fence_q;

  // Next-state for pointers, occupancy and the exception fence.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fence_d  = fence_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      fence_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && ie_in) fence_d = 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fence_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fence_q  <= fence_d;
    end
  end

endmodule

// File: rtl/mem_ex_queue.sv
// MEM -> EX decoupling queue with exception fence.
// Entry storage lives here; control lives in mem_ex_queue_ctl.
module mem_ex_queue
  import mem_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [EIP_W-1:0]     EIP_in,
  input  logic [PA_W-1:0]      PA_in,
  input  logic                 IE_in,
  input  logic [IE_TYPE_W-1:0] IE_type_in,
  input  logic [BR_W-1:0]      BR_pred_target_in,
  input  logic                 BR_pred_T_NT_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [EIP_W-1:0]     EIP_out,
  output logic [PA_W-1:0]      PA_out,
  output logic                 IE_out,
  output logic [IE_TYPE_W-1:0] IE_type_out,
  output logic [BR_W-1:0]      BR_pred_target_out,
  output logic                 BR_pred_T_NT_out,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                 fenced_out
);

  localparam int PW = $clog2(DEPTH);

  logic          push;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  mem_ex_entry_t wr_entry;
  mem_ex_entry_t rd_entry;
  mem_ex_entry_t mem_q [DEPTH];
  mem_ex_entry_t mem_d [DEPTH];

  mem_ex_queue_ctl #(
    .DEPTH(DEPTH)
  ) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .ie_in     (IE_in),
    .push      (push),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count_out),
    .fenced    (fenced_out)
  );

  assign wr_entry = '{
    eip:       EIP_in,
    pa:        PA_in,
    ie:        IE_in,
    ie_type:   IE_type_in,
    br_target: BR_pred_target_in,
    br_tnt:    BR_pred_T_NT_in
  };

  // Write the incoming entry into the tail slot on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = wr_entry;
  end

  // Entry storage; reset clears it so the head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_entry = mem_q[rd_ptr];

  assign EIP_out            = rd_entry.eip;
  assign PA_out             = rd_entry.pa;
  assign IE_out             = rd_entry.ie;
  assign IE_type_out        = rd_entry.ie_type;
  assign BR_pred_target_out = rd_entry.br_target;
  assign BR_pred_T_NT_out   = rd_entry.br_tnt;

endmodule

// File: tb/tb_mem_ex_queue.sv
// Bench for mem_ex_queue: DEPTH=2 and DEPTH=4 on shared stimulus,
// each checked against a queue-based reference.
module tb_mem_ex_queue;
  import mem_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, vin, rdy;
  mem_ex_entry_t ein;

  logic r2, v2, fe2;
  logic r4, v4, fe4;
  logic [1:0] c2;
  logic [2:0] c4;
  logic [31:0] eip2, pa2, br2, eip4, pa4, br4;
  logic ie2, tnt2, ie4, tnt4;
  logic [3:0] ty2, ty4;
  mem_ex_entry_t o2, o4;

  assign o2 = {eip2, pa2, ie2, ty2, br2, tnt2};
  assign o4 = {eip4, pa4, ie4, ty4, br4, tnt4};

  mem_ex_queue #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_in(vin), .ready_out(r2),
    .EIP_in(ein.eip), .PA_in(ein.pa), .IE_in(ein.ie),
    .IE_type_in(ein.ie_type),
    .BR_pred_target_in(ein.br_target),
    .BR_pred_T_NT_in(ein.br_tnt),
    .valid_out(v2), .ready_in(rdy),
    .EIP_out(eip2), .PA_out(pa2), .IE_out(ie2),
    .IE_type_out(ty2), .BR_pred_target_out(br2),
    .BR_pred_T_NT_out(tnt2),
    .count_out(c2), .fenced_out(fe2)
  );

  mem_ex_queue #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_in(vin), .ready_out(r4),
    .EIP_in(ein.eip), .PA_in(ein.pa), .IE_in(ein.ie),
    .IE_type_in(ein.ie_type),
    .BR_pred_target_in(ein.br_target),
    .BR_pred_T_NT_in(ein.br_tnt),
    .valid_out(v4), .ready_in(rdy),
    .EIP_out(eip4), .PA_out(pa4), .IE_out(ie4),
    .IE_type_out(ty4), .BR_pred_target_out(br4),
    .BR_pred_T_NT_out(tnt4),
    .count_out(c4), .fenced_out(fe4)
  );

  int n_pass = 0;
  int n_tot  = 0;

  mem_ex_entry_t q2[$];
  mem_ex_entry_t q4[$];
  bit f2, f4;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic mem_ex_entry_t mk(input logic [31:0] eip,
                                       input logic ie,
                                       input logic [3:0] ty);
    mem_ex_entry_t e;
    e.eip       = eip;
    e.pa        = eip ^ 32'hA5A5_0000;
    e.ie        = ie;
    e.ie_type   = ty;
    e.br_target = eip + 32'd8;
    e.br_tnt    = eip[2];
    return e;
  endfunction

  task automatic check_model();
    chk("d2_valid", v2, q2.size() != 0);
    chk("d2_count", c2, q2.size());
    chk("d2_ready", r2, (q2.size() < 2) && !f2);
    chk("d2_fence", fe2, f2);
    if (q2.size() != 0) chk("d2_head", o2, q2[0]);
    chk("d4_valid", v4, q4.size() != 0);
    chk("d4_count", c4, q4.size());
    chk("d4_ready", r4, (q4.size() < 4) && !f4);
    chk("d4_fence", fe4, f4);
    if (q4.size() != 0) chk("d4_head", o4, q4[0]);
  endtask

  // One clock: predict from pre-edge state, then compare after the edge.
  task automatic cyc();
    bit p2, p4, x2, x4;
    p2 = vin && (q2.size() < 2) && !f2 && !flush;
    p4 = vin && (q4.size() < 4) && !f4 && !flush;
    x2 = (q2.size() != 0) && rdy && !flush;
    x4 = (q4.size() != 0) && rdy && !flush;
    @(posedge clk);
    if (!rst || flush) begin
      q2.delete(); q4.delete();
      f2 = 0; f4 = 0;
    end else begin
      if (x2) void'(q2.pop_front());
      if (x4) void'(q4.pop_front());
      if (p2) begin q2.push_back(ein); if (ein.ie) f2 = 1; end
      if (p4) begin q4.push_back(ein); if (ein.ie) f4 = 1; end
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit          vin, rdy, fl;
    logic [31:0] eip;
    bit          ie;
    logic [3:0]  ty;
    bit          ev;
    logic [31:0] eeip;
    int          ecnt;
    bit          erdy, efen;
  } vec_t;

  vec_t tv[$];

  initial begin
    tv.push_back('{1,0,0,32'h100,0,4'h0, 1,32'h100,1,1,0});
    tv.push_back('{1,0,0,32'h104,0,4'h0, 1,32'h100,2,0,0});
    tv.push_back('{1,0,0,32'h108,0,4'h0, 1,32'h100,2,0,0});
    tv.push_back('{0,1,0,32'h0,  0,4'h0, 1,32'h104,1,1,0});
    tv.push_back('{0,1,0,32'h0,  0,4'h0, 0,32'h0,  0,1,0});
    tv.push_back('{1,0,0,32'h300,0,4'h0, 1,32'h300,1,1,0});
    tv.push_back('{1,0,0,32'h304,1,4'h1, 1,32'h300,2,0,1});
    tv.push_back('{1,1,0,32'h308,0,4'h0, 1,32'h304,1,0,1});
    tv.push_back('{1,1,0,32'h30C,0,4'h0, 0,32'h0,  0,0,1});
    tv.push_back('{1,0,1,32'h310,0,4'h0, 0,32'h0,  0,1,0});
    tv.push_back('{1,0,0,32'h400,0,4'h0, 1,32'h400,1,1,0});
    tv.push_back('{1,0,0,32'h404,0,4'h0, 1,32'h400,2,0,0});
    tv.push_back('{1,1,1,32'h408,0,4'h0, 0,32'h0,  0,1,0});
    tv.push_back('{0,0,0,32'h0,  0,4'h0, 0,32'h0,  0,1,0});

    rst = 0; flush = 0; vin = 0; rdy = 0;
    ein = '0;
    ein.eip = 32'hDEAD_BEEF;
    cyc();
    cyc();
    chk("rst_ready2", r2, 1'b1);
    chk("rst_ready4", r4, 1'b1);
    chk("rst_pay2", o2, '0);
    chk("rst_pay4", o4, '0);
    rst = 1;

    foreach (tv[i]) begin
      vin   = tv[i].vin;
      rdy   = tv[i].rdy;
      flush = tv[i].fl;
      ein   = mk(tv[i].eip, tv[i].ie, tv[i].ty);
      cyc();
      chk($sformatf("vec%0d_valid", i), v2, tv[i].ev);
      chk($sformatf("vec%0d_count", i), c2, tv[i].ecnt);
      chk($sformatf("vec%0d_ready", i), r2, tv[i].erdy);
      chk($sformatf("vec%0d_fence", i), fe2, tv[i].efen);
      if (tv[i].ev)
        chk($sformatf("vec%0d_eip", i), eip2, tv[i].eeip);
    end
    flush = 0;

    // Streaming with EX always ready: one per cycle, never above 1.
    for (int i = 0; i < 8; i++) begin
      vin = 1; rdy = 1;
      ein = mk(32'h200 + 32'(4 * i), 0, 4'h0);
      cyc();
      chk("stream_cnt_le1", c2 <= 2'd1, 1'b1);
      chk("stream_eip", eip2, 32'h200 + 32'(4 * i));
    end
    vin = 0;
    cyc();
    cyc();

    // Wrap-around with ready toggling and random payload.
    flush = 1; cyc(); flush = 0;
    for (int i = 0; i < 10; i++) begin
      vin = 1;
      rdy = i[1];
      ein.eip       = 32'h500 + 32'(4 * i);
      ein.pa        = $urandom;
      ein.ie        = 0;
      ein.ie_type   = 4'($urandom);
      ein.br_target = $urandom;
      ein.br_tnt    = 1'($urandom);
      cyc();
    end
    vin = 0; rdy = 1;
    for (int i = 0; i < 5; i++) cyc();

    // Reset while DEPTH=4 holds three entries and is fenced.
    flush = 1; cyc(); flush = 0;
    rdy = 0; vin = 1;
    ein = mk(32'h600, 0, 4'h0); cyc();
    ein = mk(32'h604, 0, 4'h0); cyc();
    ein = mk(32'h608, 1, 4'h2); cyc();
    chk("pre_rst_cnt4", c4, 3'd3);
    chk("pre_rst_fen4", fe4, 1'b1);
    rst = 0; cyc(); rst = 1; vin = 0;
    chk("rst4_valid", v4, 1'b0);
    chk("rst4_ready", r4, 1'b1);
    chk("rst4_count", c4, 3'd0);
    chk("rst4_fence", fe4, 1'b0);
    chk("rst4_pay", o4, '0);
    chk("rst2_pay", o2, '0);

    // Randomized traffic against the reference queues.
    for (int i = 0; i < 600; i++) begin
      vin   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) != 0);
      ein.eip       = $urandom;
      ein.pa        = $urandom;
      ein.ie        = ($urandom_range(0, 9) == 0);
      ein.ie_type   = 4'($urandom);
      ein.br_target = $urandom;
      ein.br_tnt    = 1'($urandom);
      cyc();
    end
    rst = 1; flush = 0; vin = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_ex_queue.md
# mem_ex_queue

Decoupling queue between the MEM stage (TLB lookup, segment-limit and page-fault checking) and the EX stage. Each MEM-stage result is captured into a small circular buffer and presented to EX under a valid/ready handshake, so EX back-pressure stalls only MEM. Once an excepting instruction (IE=1) is accepted, the queue fences: it accepts nothing further until a pipeline flush. Flush empties the queue and clears the fence.

## Interface
- DEPTH, 2, number of entries; legal values 2 or 4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush from the branch/exception resolver; highest priority.
- valid_in  in  1  MEM presents an entry this cycle.
- ready_out  out  1  queue accepts an entry this cycle.
- EIP_in  in  32  instruction pointer.
- PA_in  in  32  translated physical address from the TLB.
- IE_in  in  1  interrupt/exception flag.
- IE_type_in  in  4  bit0 protection, bit1 page fault, bits3:2 upstream causes.
- BR_pred_target_in  in  32  predicted branch target.
- BR_pred_T_NT_in  in  1  predicted taken.
- valid_out  out  1  head entry is valid.
- ready_in  in  1  EX consumes the head entry this cycle.
- EIP_out, PA_out, IE_out, IE_type_out, BR_pred_target_out, BR_pred_T_NT_out  out  32/32/1/4/32/1  head-entry payload.
- count_out  out  $clog2(DEPTH)+1  current occupancy.
- fenced_out  out  1  fence active.

## Operation
- push = valid_in & ready_out & ~flush.
- pop = valid_out & ready_in & ~flush.
- ready_out = (count < DEPTH) & ~fence. It depends only on state, never on ready_in. There is no same-cycle bypass when the queue is full.
- valid_out = (count != 0). Payload outputs come directly from entry[rd_ptr].
- On push: write entry[wr_ptr]; wr_ptr = (wr_ptr+1) mod DEPTH.
- On pop: rd_ptr = (rd_ptr+1) mod DEPTH.
- Count update: push only → count+1; pop only → count−1; push and pop together → count unchanged, both pointers advance.
- Fence: set when push occurs with IE_in=1. While set, ready_out=0. Entries already queued, including the excepting one, still drain normally.
- Flush: rd_ptr=wr_ptr=0, count=0, fence=0. Any concurrent push or pop is discarded. Entry storage need not be cleared.
- Reset (rst=0 at an edge): same as flush, and payload storage is zeroed.
- Reset values of outputs: valid_out=0, ready_out=1, count_out=0, fenced_out=0, all payload outputs 0.

## Timing
- Latency: an entry pushed at edge N appears on valid_out/payload in the cycle after N (one-cycle latency). There is no combinational path from input to output.
- Throughput: one entry per cycle when EX keeps ready_in=1.
- Full queue: ready_out=0 in the cycle count==DEPTH. It returns to 1 in the cycle after the first pop.
- Fence timing: fence takes effect in the cycle after the IE push, so ready_out drops in that cycle.
- Payload stability: payload holds steady while valid_out=1 and ready_in=0.
- Flush with rst=1: the queue is empty and unfenced in the cycle after the edge.
- Simultaneous rst=0 and flush=1: reset wins (identical state, plus payload cleared).

## Structure
- Package mem_pipe_pkg:
  - field widths: EIP_W=32, PA_W=32, IE_TYPE_W=4.
  - IE_type bit indices: IE_PROT=0, IE_PF=1.
  - packed entry typedef mem_ex_entry_t, 102 bits.
- One sub-module, mem_ex_queue_ctl: pointers, count, fence, and the push/pop/flush logic. The top level holds the entry register array and output muxing.

## Test plan
- Fill and drain, DEPTH=2: push EIP 0x100 and 0x104 with ready_in=0 → ready_out=0 after the second push, count_out=2. Raise ready_in → outputs 0x100 then 0x104, then valid_out=0.
- Streaming: push 0x200..0x21C on consecutive cycles with ready_in=1 → same order out, one per cycle, count_out never exceeds 1, no bubbles.
- Fence: push 0x300 (IE=0), then 0x304 with IE=1 and IE_type=0001 → fenced_out=1 and ready_out=0 the next cycle. Both entries drain. ready_out stays 0 until flush; after flush, ready_out=1 and fenced_out=0.
- Flush mid-traffic: count=2 with flush=1, valid_in=1, ready_in=1 in the same cycle → next cycle count_out=0, valid_out=0, nothing accepted or consumed.
- Wrap-around, DEPTH=4: 10 push/pop cycles with ready_in toggling every other cycle → FIFO order preserved across pointer wrap; PA and BR fields match what was pushed.
- Reset mid-operation: count=3, fenced, rst=0 for one edge → valid_out=0, ready_out=1, count_out=0, fenced_out=0, all payload outputs 0.
